serial_adder: RTL and testbench

- Bit-serial WIDTH-bit adder built around the team's 1-bit full-adder cell.
- Adds one bit pair per clock, LSB first, and stores the carry in a flip-flop between bits.
- Serves as the sequential stage downstream of the combinational full adder: it consumes the cell's z/cout every cycle and packs them into a WIDTH-bit sum with a start/busy/done handshake.
- Used by the lab's arithmetic unit where area matters more than latency.

---
 rtl/serial_adder_if.sv | 20 ++
 rtl/serial_adder.sv | 91 +++++++++
 tb/tb_serial_adder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder.
//   start/a/b/cin : request and operands, driven by the requester
//   busy/done     : progress status and one-cycle completion pulse
//   sum/cout      : result of the last completed addition
// The master modport belongs to the requester; the slave modport belongs to the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Each cycle a 1-bit full-adder cell adds one bit pair,
// LSB first, and the carry is held in a flip-flop until the next bit.
// Ports:
//   clk   : rising-edge clock
//   rst_b : asynchronous active-low reset
//   bus   : serial_adder_if.slave
//           start/a/b/cin in; busy/done/sum/cout out
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// ADD   | one bit pair consumed per clock, WIDTH clocks in total
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_b,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, ADD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, r_q, sum_q;
  logic             c_q, cout_q, done_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_s, fa_c, last_bit;

  // Full-adder cell on the current LSBs and the stored carry.
  assign fa_s = a_q[0] ^ b_q[0] ^ c_q;
  assign fa_c = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  assign last_bit = (state_q == ADD) && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ADD;
      ADD:     if (last_bit)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.start) begin
          a_q   <= bus.a;
          b_q   <= bus.b;
          c_q   <= bus.cin;
          r_q   <= '0;
          cnt_q <= '0;
        end
      end else begin
        a_q   <= a_q >> 1;
        b_q   <= b_q >> 1;
        r_q   <= {fa_s, r_q[WIDTH-1:1]};
        c_q   <= fa_c;
        cnt_q <= cnt_q + 1'b1;
        // The final bit goes straight into sum; r_q is not yet fully shifted.
        if (last_bit) begin
          sum_q  <= {fa_s, r_q[WIDTH-1:1]};
          cout_q <= fa_c;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (state_q == ADD);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized bench for serial_adder, using one WIDTH=8 instance and
// one WIDTH=4 instance. Outputs are sampled on the falling clock edge.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_b(rst_b), .bus(bus8));
  serial_adder #(.WIDTH(4)) u4 (.clk(clk), .rst_b(rst_b), .bus(bus4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // done must never coincide with busy and must last exactly one cycle.
  logic prev_done8 = 1'b0, prev_done4 = 1'b0;
  always @(negedge clk) begin
    if (rst_b) begin
      check("busy_and_done8", {31'd0, bus8.busy & bus8.done}, 32'd0);
      check("done_width8", {31'd0, prev_done8 & bus8.done}, 32'd0);
      check("busy_and_done4", {31'd0, bus4.busy & bus4.done}, 32'd0);
      check("done_width4", {31'd0, prev_done4 & bus4.done}, 32'd0);
      prev_done8 = bus8.done;
      prev_done4 = bus4.done;
    end else begin
      prev_done8 = 1'b0;
      prev_done4 = 1'b0;
    end
  end

  // Present a one-cycle start; returns at the falling edge after the start edge.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  // From the falling edge after the start edge, count edges until done is seen.
  task automatic wait_done8(output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    while (!bus8.done && edges < 40) begin
      if (bus8.busy) busy_cnt++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input string tag);
    int e, bc;
    logic [8:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    start8(a, b, cin);
    wait_done8(e, bc);
    check({tag, "_latency"}, e, 8);
    check({tag, "_result"}, {23'd0, bus8.cout, bus8.sum}, {23'd0, exp});
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int e;
    logic [4:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.cin = cin;
    @(negedge clk);
    bus4.start = 1'b0;
    e = 0;
    while (!bus4.done && e < 20) begin
      @(negedge clk);
      e++;
    end
    check("w4_latency", e, 4);
    check("w4_result", {27'd0, bus4.cout, bus4.sum}, {27'd0, exp});
  endtask

  initial begin
    int e, bc, dcnt;
    logic [7:0] cap;
    logic held_ok;

    rst_b = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    #12;
    check("rst_outputs", {22'd0, bus8.busy, bus8.done, bus8.cout, bus8.sum},
          32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // Basic: 0x5A + 0x33 = 0x8D
    start8(8'h5A, 8'h33, 1'b0);
    wait_done8(e, bc);
    check("basic_latency", e, 8);
    check("basic_busy_cycles", bc, 8);
    check("basic_sum", {24'd0, bus8.sum}, 32'h8D);
    check("basic_cout", {31'd0, bus8.cout}, 32'd0);
    @(negedge clk);
    check("basic_done_clears", {31'd0, bus8.done}, 32'd0);

    // Reset mid-operation
    start8(8'hFF, 8'hFF, 1'b1);
    @(negedge clk); @(negedge clk);
    check("pre_rst_busy", {31'd0, bus8.busy}, 32'd1);
    #2 rst_b = 1'b0;
    #1;
    check("midrst_outputs", {22'd0, bus8.busy, bus8.done, bus8.cout, bus8.sum},
          32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_outputs", {22'd0, bus8.busy, bus8.done, bus8.cout, bus8.sum},
          32'd0);

    // Carry chain
    op8(8'hFF, 8'h01, 1'b0, "carry_ff_01");
    op8(8'hFF, 8'hFF, 1'b1, "carry_ff_ff_1");
    op8(8'h00, 8'h00, 1'b1, "cin_only");

    // Start while busy is ignored
    start8(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.cin = 1'b0;
    dcnt = 0;
    cap = 8'h00;
    repeat (20) begin
      if (bus8.done) begin
        dcnt++;
        cap = bus8.sum;
        check("ignored_cout", {31'd0, bus8.cout}, 32'd0);
      end
      @(negedge clk);
    end
    check("ignored_done_count", dcnt, 1);
    check("ignored_sum", {24'd0, cap}, 32'h30);

    // Back-to-back: start accepted in the done cycle
    start8(8'h01, 8'h02, 1'b0);
    wait_done8(e, bc);
    check("b2b_first_sum", {24'd0, bus8.sum}, 32'h03);
    bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    check("b2b_busy_rises", {30'd0, bus8.busy, bus8.done}, 32'b10);
    held_ok = 1'b1;
    e = 0;
    while (!bus8.done && e < 40) begin
      if (bus8.sum !== 8'h03 || bus8.cout !== 1'b0) held_ok = 1'b0;
      @(negedge clk);
      e++;
    end
    check("b2b_sum_held", {31'd0, held_ok}, 32'd1);
    check("b2b_latency", e, 8);
    check("b2b_second", {23'd0, bus8.cout, bus8.sum}, 32'h100);

    // Exhaustive WIDTH=4
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      op4(v[8:5], v[4:1], v[0]);
    end

    // Random WIDTH=8
    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
